// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and halt controller for the 16-bit 5-stage pipeline.
//
// Watches the ID and EX stages and generates the per-cycle PC / IF/ID / ID/EX controls:
// branch flush, load-use stall and halt drain. Keeps saturating stall/flush statistics.
//
// Ports:
//   clk, rst                 pipeline clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt             source register fields of the ID instruction
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   id_halt                  ID instruction is HALT
//   ex_memread, ex_regwrite  EX instruction is a load / writes a register
//   ex_rd                    EX destination register
//   ex_branch_taken          EX instruction is a resolved taken branch or jump
//   StopPC, Halt             PC controls: re-fetch current instruction / freeze PC
//   ifid_hold, ifid_flush    IF/ID keeps contents / loads a NOP
//   idex_bubble              ID/EX loads a NOP
//   halted                   pipeline drained and stopped (registered)
//   stall_cnt, flush_cnt     saturating load-use stall / branch flush cycle counts

module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter bit          R0_HARDWIRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_halt,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [3:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        StopPC,
    output logic        Halt,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        hz;
    logic        stall_inc, flush_inc;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    assign hz = ex_memread & ex_regwrite & ((ex_rd != 4'd0) | !R0_HARDWIRED) &
                ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        StopPC      = 1'b0;
        Halt        = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            StRun: begin
                // Taken branch wins: the ID instruction is wrong-path, so its hazard or
                // HALT must not act.
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                end else if (hz) begin
                    StopPC      = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (id_halt) begin
                    Halt        = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = StDrain;
                    dcnt_d      = DrainInit;
                end
            end
            StDrain: begin
                Halt        = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
                if (dcnt_q == 4'd0) begin
                    state_d = StHalted;
                end else begin
                    dcnt_d = dcnt_q - 4'd1;
                end
            end
            StHalted: begin
                Halt        = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            default: state_d = StRun;
        endcase
        // Controls are forced quiet for the whole time reset is held, not just at its edge.
        if (!rst) begin
            StopPC      = 1'b0;
            Halt        = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            dcnt_q      <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign halted    = (state_q == StHalted);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the hazard/halt rules.

module tb_pipe_hazard_ctrl;

    localparam int unsigned D  = 3;
    localparam bit          R0 = 1'b1;

    logic        clk, rst;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_halt;
    logic        ex_memread, ex_regwrite, ex_branch_taken;
    logic        StopPC, Halt, ifid_hold, ifid_flush, idex_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES (D),
        .R0_HARDWIRED (R0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_halt         (id_halt),
        .ex_memread      (ex_memread),
        .ex_regwrite     (ex_regwrite),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .StopPC          (StopPC),
        .Halt            (Halt),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // age: edges since HALT was accepted (0 = still running normally).
    int m_age   = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic bit load_use();
        bit dst_real, reads_dst;
        dst_real  = !(R0 && ex_rd == 4'd0);
        reads_dst = (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
        return ex_memread && ex_regwrite && dst_real && reads_dst;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else if (m_age == 0) begin
            if (ex_branch_taken)  m_flush <= (m_flush < 65535) ? m_flush + 1 : m_flush;
            else if (load_use())  m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
            else if (id_halt)     m_age   <= 1;
        end else if (m_age < 100) begin
            m_age <= m_age + 1;
        end
    end

    // Compare process: mid-cycle, inputs and registered outputs are stable.
    always @(negedge clk) begin
        logic [4:0] e; // {StopPC, Halt, ifid_hold, ifid_flush, idex_bubble}
        if (!rst)                 e = 5'b00000;
        else if (m_age > 0)       e = 5'b01101;
        else if (ex_branch_taken) e = 5'b00011;
        else if (load_use())      e = 5'b10101;
        else if (id_halt)         e = 5'b01101;
        else                      e = 5'b00000;
        chk("m_StopPC",      32'(StopPC),      32'(e[4]));
        chk("m_Halt",        32'(Halt),        32'(e[3]));
        chk("m_ifid_hold",   32'(ifid_hold),   32'(e[2]));
        chk("m_ifid_flush",  32'(ifid_flush),  32'(e[1]));
        chk("m_idex_bubble", 32'(idex_bubble), 32'(e[0]));
        chk("m_halted",      32'(halted),      32'(m_age >= int'(D) + 1));
        chk("m_stall_cnt",   32'(stall_cnt),   32'(m_stall));
        chk("m_flush_cnt",   32'(flush_cnt),   32'(m_flush));
        chk("inv_stop_halt", 32'(StopPC & Halt),          32'd0);
        chk("inv_hold_flush", 32'(ifid_hold & ifid_flush), 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_halt = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] rd);
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
        id_rs = rd; id_uses_rs = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) cyc();
        chk("rst_Halt", 32'(Halt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        #1 rst = 1'b1;
        cyc();

        // Load-use on r3: one-cycle stall.
        set_load_use(4'd3);
        #1;
        chk("lu_StopPC", 32'(StopPC), 32'd1);
        chk("lu_hold", 32'(ifid_hold), 32'd1);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        cyc();
        idle();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load into r0 with r0 hardwired: no stall.
        set_load_use(4'd0);
        #1;
        chk("r0_StopPC", 32'(StopPC), 32'd0);
        cyc();
        chk("r0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Taken branch overrides hazard and HALT.
        set_load_use(4'd5);
        id_halt = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_bubble", 32'(idex_bubble), 32'd1);
        chk("br_StopPC", 32'(StopPC), 32'd0);
        chk("br_Halt", 32'(Halt), 32'd0);
        cyc();
        idle();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        #1;
        chk("br_still_run", 32'(Halt), 32'd0);

        // Back-to-back branches and back-to-back dependent loads.
        ex_branch_taken = 1'b1;
        cyc();
        cyc();
        idle();
        chk("b2b_flush_cnt", 32'(flush_cnt), 32'd3);
        set_load_use(4'd7);
        cyc();
        set_load_use(4'd9);
        cyc();
        idle();
        chk("b2b_stall_cnt", 32'(stall_cnt), 32'd3);

        // Random stimulus (no HALT) for model and invariant checking.
        for (int i = 0; i < 400; i++) begin
            id_rs = 4'($urandom_range(0, 3));
            id_rt = 4'($urandom_range(0, 3));
            ex_rd = 4'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            ex_memread = 1'($urandom);
            ex_regwrite = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            cyc();
        end
        idle();

        // Saturation: 70000 stall cycles.
        set_load_use(4'd2);
        for (int i = 0; i < 70000; i++) cyc();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        cyc();
        chk("sat_no_wrap", 32'(stall_cnt), 32'h0000_FFFF);
        idle();
        cyc();

        // Halt drain.
        id_halt = 1'b1;
        #1;
        chk("hd_Halt_issue", 32'(Halt), 32'd1);
        chk("hd_StopPC_issue", 32'(StopPC), 32'd0);
        cyc();                                // edge 1
        idle();
        ex_branch_taken = 1'b1;
        set_load_use(4'd4);
        chk("hd_halted_e1", 32'(halted), 32'd0);
        chk("hd_Halt_e1", 32'(Halt), 32'd1);
        chk("hd_flush_e1", 32'(ifid_flush), 32'd0);
        cyc();                                // edge 2
        chk("hd_halted_e2", 32'(halted), 32'd0);
        cyc();                                // edge 3
        chk("hd_halted_e3", 32'(halted), 32'd0);
        cyc();                                // edge 4
        chk("hd_halted_e4", 32'(halted), 32'd1);
        chk("hd_Halt_e4", 32'(Halt), 32'd1);
        repeat (3) cyc();
        chk("hd_stall_frozen", 32'(stall_cnt), 32'h0000_FFFF);
        chk("hd_halted_stays", 32'(halted), 32'd1);
        idle();

        // Reset, then re-halt and reset mid-DRAIN.
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        cyc();
        id_halt = 1'b1;
        cyc();                                // now in DRAIN
        idle();
        set_load_use(4'd6);
        ex_branch_taken = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mr_Halt", 32'(Halt), 32'd0);
        chk("mr_hold", 32'(ifid_hold), 32'd0);
        chk("mr_flush", 32'(ifid_flush), 32'd0);
        chk("mr_bubble", 32'(idex_bubble), 32'd0);
        chk("mr_StopPC", 32'(StopPC), 32'd0);
        chk("mr_halted", 32'(halted), 32'd0);
        chk("mr_flush_cnt", 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        idle();
        #1;
        chk("rel_Halt", 32'(Halt), 32'd0);
        chk("rel_bubble", 32'(idex_bubble), 32'd0);
        cyc();
        chk("rel_halted", 32'(halted), 32'd0);
        chk("rel_Halt_e1", 32'(Halt), 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and halt controller for the 16-bit 5-stage pipeline. It watches the ID and EX stages and produces the per-cycle hold, flush and bubble controls for the program counter, IF/ID and ID/EX registers. It drives the PC's `StopPC` (re-fetch the current instruction, PC <= NewPC-2) and `Halt` (freeze PC) inputs. It runs a halt-drain state machine and keeps saturating stall/flush statistics.

## Interface
- `DRAIN_CYCLES`, 3: cycles after halt issue for older instructions to leave EX/MEM/WB; legal 1..15.
- `R0_HARDWIRED`, 1: when 1, a destination of register 0 never causes a load-use stall.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 4: source register fields of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads rs / rt.
- `id_halt` in 1: the ID instruction is HALT.
- `ex_memread`, `ex_regwrite` in 1: the EX instruction is a load / writes a register.
- `ex_rd` in 4: destination register of the EX instruction.
- `ex_branch_taken` in 1: the EX instruction is a resolved taken branch or jump.
- `StopPC` out 1: to PC; re-fetch the current instruction.
- `Halt` out 1: to PC; hold PC.
- `ifid_hold` out 1: IF/ID keeps its contents.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_bubble` out 1: ID/EX loads a NOP instead of the ID instruction.
- `halted` out 1: the pipeline is fully drained and stopped.
- `stall_cnt` out 16: count of load-use stall cycles, saturating.
- `flush_cnt` out 16: count of branch flush cycles, saturating.

## Operation
- States are RUN, DRAIN and HALTED, plus a 4-bit drain counter `dcnt`.
- `hz` (load-use hazard) is `ex_memread & ex_regwrite & (ex_rd!=0 | !R0_HARDWIRED) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- RUN has a fixed priority order; exactly one case applies per cycle:
  1. `ex_branch_taken` → `ifid_flush=1`, `idex_bubble=1`, `StopPC=0`, `Halt=0`; `flush_cnt++`. The ID instruction is wrong-path, so `hz` and `id_halt` are ignored. Stay in RUN.
  2. `hz` → `StopPC=1`, `ifid_hold=1`, `idex_bubble=1`; `stall_cnt++`. Stay in RUN. The following cycle re-evaluates with the load now in MEM, so a single load produces exactly a 1-cycle stall.
  3. `id_halt` → `Halt=1`, `ifid_hold=1`, `idex_bubble=1`. Go to DRAIN with `dcnt=DRAIN_CYCLES-1`.
  4. Otherwise all controls are 0.
- DRAIN: `Halt=1`, `ifid_hold=1`, `idex_bubble=1`, all other controls 0.
  - If `dcnt==0`, go to HALTED; otherwise `dcnt--`.
  - All EX/ID inputs are ignored (only bubbles are in flight behind HALT).
- HALTED: `Halt=1`, `ifid_hold=1`, `idex_bubble=1`, `halted=1`. Left only by reset.
- Counters:
  - Each counter increments by 1 per qualifying cycle and stops at 16'hFFFF (no wrap).
  - Counters never change in DRAIN or HALTED.
- `StopPC` and `Halt` are never both 1.
- `ifid_hold` and `ifid_flush` are never both 1.

## Timing
- All control outputs are combinational from the current state and the current-cycle inputs (Mealy). They are valid before the same rising edge that updates PC, IF/ID and ID/EX. Hazard-to-action latency is 0 cycles.
- `halted`, `stall_cnt` and `flush_cnt` are registered.
  - `halted` rises exactly `DRAIN_CYCLES+1` edges after the edge that samples `id_halt` in RUN.
  - A counter reflects a qualifying cycle 1 edge later.
- Reset (asynchronous assert, any state including mid-DRAIN):
  - State goes to RUN, `dcnt=0`, `halted=0`, `stall_cnt=0`, `flush_cnt=0`.
  - While `rst=0`, all control outputs are forced to 0 regardless of inputs.
  - After release, the first rising edge evaluates in RUN.
- Back-to-back: a taken branch in consecutive cycles flushes in each cycle. A second dependent load immediately after a stall produces its own 1-cycle stall.

## Test plan
- Load-use: EX load `ex_rd=3`, ID `id_rs=3`, `id_uses_rs=1` for 1 cycle → `StopPC=1`, `ifid_hold=1`, `idex_bubble=1` that cycle; `stall_cnt` reads 1 after the edge. With `ex_rd=0` and `R0_HARDWIRED=1` → no stall.
- Branch over hazard and halt: `ex_branch_taken=1` with `hz` true and `id_halt=1` → `ifid_flush=1`, `idex_bubble=1`, `StopPC=0`, `Halt=0`; `flush_cnt` increments to 1; state remains RUN.
- Halt drain (`DRAIN_CYCLES=3`): `id_halt=1` in RUN → `Halt=1` that cycle and every later cycle. `halted` reads 0 after edges 1–3 and 1 after edge 4. Inputs toggled during DRAIN/HALTED have no effect.
- Reset mid-DRAIN: assert `rst=0` asynchronously between edges while in DRAIN → all outputs are 0 immediately. After release, a plain RUN cycle produces all controls 0 and `halted=0`.
- Saturation: force 70000 stall cycles → `stall_cnt` holds at 16'hFFFF and does not wrap.
- Invariant check over random stimulus: `StopPC&Halt==0` and `ifid_hold&ifid_flush==0` on every cycle.
